// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the CPU datapath and a word-only data memory.
// Sub-word stores are done as read-modify-write; bad requests never strobe memory.
module mem_access_ctrl #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  off_q;
    logic [15:0] wd_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        req_err_d;
    logic [7:0]  lane_b_d;
    logic [15:0] lane_h_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    // Classify the incoming request: misaligned, out of range or reserved size.
    always_comb begin
        req_err_d = 1'b0;
        unique case (1'b1)
            (size == 2'b11):                    req_err_d = 1'b1;
            (addr >= 32'(ADDR_LIMIT)):          req_err_d = 1'b1;
            (size == SZ_HALF && addr[0]):       req_err_d = 1'b1;
            (size == SZ_WORD && addr[1:0] != 2'b00):
                                                req_err_d = 1'b1;
            default:                            req_err_d = 1'b0;
        endcase
    end

    // Extract the load lane and build the merged word for sub-word stores.
    always_comb begin
        lane_b_d = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h_d = mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_d   = mem_rdata;
        merge_d  = mem_rdata;
        unique case (size_q)
            SZ_BYTE: begin
                load_d = {{24{sext_q & lane_b_d[7]}}, lane_b_d};
                merge_d[{off_q, 3'b000} +: 8] = wd_q[7:0];
            end
            SZ_HALF: begin
                load_d = {{16{sext_q & lane_h_d[15]}}, lane_h_d};
                merge_d[{off_q[1], 4'b0000} +: 16] = wd_q;
            end
            default: begin
                load_d  = mem_rdata;
                merge_d = mem_rdata;
            end
        endcase
    end

    // Access sequencer; every output is a register set on entry to its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            off_q       <= 2'b00;
            wd_q        <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q       <= we;
                        size_q     <= size;
                        sext_q     <= sign_ext;
                        off_q      <= addr[1:0];
                        wd_q       <= wdata[15:0];
                        mem_addr_q <= {addr[31:2], 2'b00};
                        busy_q     <= 1'b1;
                        if (req_err_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (we && size == SZ_WORD) begin
                            state_q     <= S_WR;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= wdata;
                            err_q       <= 1'b0;
                        end else begin
                            state_q  <= S_RD;
                            mem_rd_q <= 1'b1;
                            err_q    <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    mem_rd_q <= 1'b0;
                    if (we_q) begin
                        mem_wdata_q <= merge_d;
                        mem_wr_q    <= 1'b1;
                        state_q     <= S_WR;
                    end else begin
                        rdata_q <= load_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WR: begin
                    mem_wr_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
